// File: rtl/des_decrypt.sv
// Iterative DES decryption engine. One ciphertext block and key are accepted
// on a valid/ready handshake, ROUNDS_PER_CLK Feistel rounds run per clock, and
// the registered plaintext is offered on a second valid/ready handshake.
// The subkey schedule runs backwards (right rotations from the unrotated PC-1
// output) so K16 is applied first.
// Bit 0 of each 64-bit bus is DES bit 1.
// Optional build macro DES_KEY_PARITY_EN adds the key_err output (key byte
// with even parity detected at accept).
module des_decrypt #(
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] data,
  input  logic        data_vld,
  output logic        data_rdy,
  input  logic [0:63] key,
  output logic [0:63] result,
  output logic        result_vld,
  input  logic        result_rdy
`ifdef DES_KEY_PARITY_EN
  ,
  output logic        key_err
`endif
);

  if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4) begin : g_bad_rpc
    $error("des_decrypt: ROUNDS_PER_CLK must be 1, 2 or 4");
  end

  localparam logic [3:0] STEP = 4'(ROUNDS_PER_CLK);
  localparam logic [3:0] LAST = 4'(16 - ROUNDS_PER_CLK);

  // Permutation tables hold 1-based DES bit numbers.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // S-boxes S1..S8, each 4 rows of 16, indexed box*64 + row*16 + col.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [0:63] f_ip(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[IP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:63] f_fp(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:47] f_e(input logic [0:31] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[i] = x[E_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:31] f_p(input logic [0:31] x);
    logic [0:31] y;
    for (int i = 0; i < 32; i++) y[i] = x[P_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:55] f_pc1(input logic [0:63] x);
    logic [0:55] y;
    for (int i = 0; i < 56; i++) y[i] = x[PC1_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:47] f_pc2(input logic [0:55] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[i] = x[PC2_T[i] - 1];
    return y;
  endfunction

  // Row is formed from the outer bits of each 6-bit group, column from the inner four.
  function automatic logic [0:31] f_sbox(input logic [0:47] x);
    logic [0:31] y;
    logic [0:5]  b;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      b = x[6*k +: 6];
      y[4*k +: 4] = 4'(SBOX[k*64 + int'({b[0], b[5], b[1:4]})]);
    end
    return y;
  endfunction

  function automatic logic [0:27] f_rotr(input logic [0:27] x, input int n);
    logic [0:27] y;
    for (int i = 0; i < 28; i++) y[i] = x[(i + 28 - n) % 28];
    return y;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [0:31] r_l, r_r;
  logic [0:27] r_c, r_d;
  logic [0:63] r_result;
  logic        r_data_rdy;
  logic        r_result_vld;

  logic [0:31] w_l, w_r, w_tmp;
  logic [0:27] w_c, w_d;
  logic [3:0]  w_idx;
  int          w_sh;

  // Unrolled chain of ROUNDS_PER_CLK rounds starting from the current registers.
  always_comb begin
    w_l   = r_l;
    w_r   = r_r;
    w_c   = r_c;
    w_d   = r_d;
    w_tmp = '0;
    w_idx = r_cnt;
    w_sh  = 2;
    for (int j = 0; j < ROUNDS_PER_CLK; j++) begin
      w_idx = r_cnt + 4'(j);
      w_tmp = w_r;
      w_r   = w_l ^ f_p(f_sbox(f_e(w_r) ^ f_pc2({w_c, w_d})));
      w_l   = w_tmp;
      w_sh  = (w_idx == 4'd0 || w_idx == 4'd7 || w_idx == 4'd14) ? 1 : 2;
      w_c   = f_rotr(w_c, w_sh);
      w_d   = f_rotr(w_d, w_sh);
    end
  end

`ifdef DES_KEY_PARITY_EN
  logic r_par_bad;
  logic r_key_err;
  logic w_par_bad;

  // Flags a key byte with even parity; DES keys carry odd parity per byte.
  always_comb begin
    w_par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (~^key[8*b +: 8]) w_par_bad = 1'b1;
    end
  end

  assign key_err = r_key_err;
`endif

  // Control FSM with the round datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_l          <= '0;
      r_r          <= '0;
      r_c          <= '0;
      r_d          <= '0;
      r_result     <= '0;
      r_data_rdy   <= 1'b1;
      r_result_vld <= 1'b0;
`ifdef DES_KEY_PARITY_EN
      r_par_bad    <= 1'b0;
      r_key_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_vld) begin
            {r_l, r_r} <= f_ip(data);
            {r_c, r_d} <= f_pc1(key);
            r_cnt      <= '0;
            r_data_rdy <= 1'b0;
            r_state    <= S_ROUND;
`ifdef DES_KEY_PARITY_EN
            r_par_bad  <= w_par_bad;
`endif
          end
        end
        S_ROUND: begin
          r_l   <= w_l;
          r_r   <= w_r;
          r_c   <= w_c;
          r_d   <= w_d;
          r_cnt <= r_cnt + STEP;
          if (r_cnt == LAST) begin
            r_result     <= f_fp({w_r, w_l});
            r_result_vld <= 1'b1;
            r_state      <= S_DONE;
`ifdef DES_KEY_PARITY_EN
            r_key_err    <= r_par_bad;
`endif
          end
        end
        S_DONE: begin
          if (result_rdy) begin
            r_result_vld <= 1'b0;
            r_data_rdy   <= 1'b1;
            r_state      <= S_IDLE;
`ifdef DES_KEY_PARITY_EN
            r_key_err    <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_rdy   = r_data_rdy;
  assign result     = r_result;
  assign result_vld = r_result_vld;

endmodule

// File: tb/tb_des_decrypt.sv
// Scoreboard bench for des_decrypt: three engines (1, 2 and 4 rounds per clock)
// share data/key/reset; each has its own handshakes. Expected plaintexts are
// known DES test vectors.
module tb_des_decrypt;

  localparam logic [63:0] V1K = 64'h133457799BBCDFF1;
  localparam logic [63:0] V1C = 64'h85E813540F0AB405;
  localparam logic [63:0] V1P = 64'h0123456789ABCDEF;
  localparam logic [63:0] V2K = 64'h0E329232EA6D0D73;
  localparam logic [63:0] V2C = 64'h0000000000000000;
  localparam logic [63:0] V2P = 64'h8787878787878787;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
    int          hold;
    logic        kerr;
    int          unit;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [0:63]      data, key;
  logic [2:0]       dv, rr, dr, rv;
  logic [2:0][63:0] res;
`ifdef DES_KEY_PARITY_EN
  logic [2:0]       ke;
`endif

  exp_t sbq[$];
  exp_t cur[3];
  int   vcnt[3];
  logic [2:0] prev = 3'b000;
  int   mon_idx;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_decrypt #(.ROUNDS_PER_CLK(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(dv[0]), .data_rdy(dr[0]),
    .key(key), .result(res[0]), .result_vld(rv[0]), .result_rdy(rr[0])
`ifdef DES_KEY_PARITY_EN
    , .key_err(ke[0])
`endif
  );

  des_decrypt #(.ROUNDS_PER_CLK(2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(dv[1]), .data_rdy(dr[1]),
    .key(key), .result(res[1]), .result_vld(rv[1]), .result_rdy(rr[1])
`ifdef DES_KEY_PARITY_EN
    , .key_err(ke[1])
`endif
  );

  des_decrypt #(.ROUNDS_PER_CLK(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(dv[2]), .data_rdy(dr[2]),
    .key(key), .result(res[2]), .result_vld(rv[2]), .result_rdy(rr[2])
`ifdef DES_KEY_PARITY_EN
    , .key_err(ke[2])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit pending(input int u);
    foreach (sbq[i]) if (sbq[i].unit == u) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: pops the scoreboard on each rising result_vld and checks outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 3; u++) begin
        if (rv[u] && !prev[u]) begin
          mon_idx = -1;
          for (int i = 0; i < sbq.size(); i++)
            if (mon_idx < 0 && sbq[i].unit == u) mon_idx = i;
          if (mon_idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result unit=%0d actual=%h required=no_output", u, res[u]);
            cur[u].res  = res[u];
            cur[u].hold = 0;
            cur[u].kerr = 1'b0;
          end else begin
            cur[u] = sbq[mon_idx];
            sbq.delete(mon_idx);
            chk($sformatf("plaintext_u%0d", u), res[u], cur[u].res);
            chk($sformatf("latency_u%0d", u), 64'(cyc - cur[u].acc), 64'(cur[u].lat));
          end
          vcnt[u] = 1;
        end else if (rv[u]) begin
          chk($sformatf("result_stable_u%0d", u), res[u], cur[u].res);
          vcnt[u]++;
        end
        if (!rv[u] && prev[u] && cur[u].hold != 0)
          chk($sformatf("vld_cycles_u%0d", u), 64'(vcnt[u]), 64'(cur[u].hold));
        if (rv[u]) begin
          chk($sformatf("rdy_low_done_u%0d", u), 64'(dr[u]), 64'd0);
`ifdef DES_KEY_PARITY_EN
          chk($sformatf("key_err_done_u%0d", u), 64'(ke[u]), 64'(cur[u].kerr));
`endif
        end else begin
          if (pending(u)) chk($sformatf("rdy_low_round_u%0d", u), 64'(dr[u]), 64'd0);
`ifdef DES_KEY_PARITY_EN
          chk($sformatf("key_err_idle_u%0d", u), 64'(ke[u]), 64'd0);
`endif
        end
      end
      prev = rv;
    end else begin
      prev = 3'b000;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int u, input logic [63:0] d, input logic [63:0] k,
                      input logic [63:0] p, input int hold, input logic kerr);
    exp_t e;
    int   n;
    data  = d;
    key   = k;
    dv[u] = 1'b1;
    n = 0;
    while (!dr[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!dr[u]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout unit=%0d actual=rdy_low required=rdy_high", u);
      dv[u] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res  = p;
    e.acc  = cyc;
    e.lat  = 16 >> u;
    e.hold = hold;
    e.kerr = kerr;
    e.unit = u;
    sbq.push_back(e);
    dv[u] = 1'b0;
    data  = {$urandom, $urandom};
    key   = {$urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    while ((pending(u) || rv[u]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pending(u) || rv[u]) begin
      checks++;
      errors++;
      $display("FAIL result_timeout unit=%0d actual=busy required=idle", u);
    end
    @(negedge clk);
  endtask

  task automatic run(input int u, input logic [63:0] d, input logic [63:0] k,
                     input logic [63:0] p, input logic kerr);
    send(u, d, k, p, 1, kerr);
    wait_idle(u);
    chk($sformatf("result_held_u%0d", u), res[u], p);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    dv    = 3'b000;
    rr    = 3'b111;
    data  = '0;
    key   = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset_rdy_u%0d", u), 64'(dr[u]), 64'd1);
      chk($sformatf("reset_vld_u%0d", u), 64'(rv[u]), 64'd0);
      chk($sformatf("reset_result_u%0d", u), res[u], 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run(0, V1C, V1K, V1P, 1'b0);
    run(0, V2C, V2K, V2P, 1'b0);
    run(1, V2C, V2K, V2P, 1'b0);
    run(2, V2C, V2K, V2P, 1'b0);
    run(1, V1C, V1K, V1P, 1'b0);
    run(2, V1C, V1K, V1P, 1'b0);

    // Downstream stall with a new block already waiting.
    rr[0] = 1'b0;
    send(0, V2C, V2K, V2P, 11, 1'b0);
    n = 0;
    while (!rv[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_vld_seen", 64'(rv[0]), 64'd1);
    fork
      send(0, V1C, V1K, V1P, 1, 1'b0);
      begin
        repeat (10) @(negedge clk);
        rr[0] = 1'b1;
      end
    join
    wait_idle(0);
    chk("stall_next_block", res[0], V1P);

    // Reset in the middle of a block.
    send(0, V2C, V2K, V2P, 1, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].unit == 0) sbq.delete(i);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rdy", 64'(dr[0]), 64'd1);
    chk("abort_vld", 64'(rv[0]), 64'd0);
    chk("abort_result", res[0], 64'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_output", 64'(rv[0]), 64'd0);
    run(0, V1C, V1K, V1P, 1'b0);

`ifdef DES_KEY_PARITY_EN
    run(0, V1C, 64'h133457799BBCDFF0, V1P, 1'b1);
    run(0, V1C, 64'h133457799BBCDFF1, V1P, 1'b0);
    run(2, V2C, V2K, V2P, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
